// File: rtl/exec_step_controller.sv
// exec_step_controller: run/step/halt sequencer for the single-cycle core.
// Produces a registered one-cycle cpu_en that gates all architectural updates,
// holds the core in reset after board reset, debounces the step button and
// stops the core when pc reaches halt_addr.
//
// state | meaning
// IDLE  | core parked, no enables issued; waits for a step or run mode
// RUN   | free-run (mode 10) or rate-limited run (mode 11)
// STEP  | one cpu_en per debounced rising edge of step_btn
// HALT  | pc reached halt_addr; only mode 00 releases back to IDLE
module exec_step_controller #(
    parameter int PC_WIDTH        = 32,
    parameter int RATE_WIDTH      = 24,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_HOLD      = 2,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode_sw,
    input  logic                   step_btn,
    input  logic [RATE_WIDTH-1:0]  rate_div,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [PC_WIDTH-1:0]    halt_addr,
    output logic                   cpu_en,
    output logic                   cpu_reset,
    output logic [1:0]             state,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
    localparam logic [DB_W-1:0]   DB_INIT   = DB_W'(DEBOUNCE_CYCLES - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic                    cpu_en_d;
    logic [RATE_WIDTH-1:0]   rate_cnt_q;
    logic [RATE_WIDTH-1:0]   rate_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    hold_active;
    logic                    btn_sync1;
    logic                    btn_sync2;
    logic                    db_level;
    logic                    db_level_q;
    logic [DB_W-1:0]         db_cnt;
    logic                    step_pulse;
    logic                    at_halt;

    assign at_halt     = (pc == halt_addr);
    assign hold_active = reset || (hold_cnt != '0);
    assign step_pulse  = db_level & ~db_level_q;
    assign state       = state_q;

    // Reset hold: cpu_reset stays up RESET_HOLD cycles past reset release, via a down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= HOLD_INIT;
            cpu_reset <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt  <= hold_cnt - 1'b1;
            cpu_reset <= 1'b1;
        end else begin
            cpu_reset <= 1'b0;
        end
    end

    // Button path: two-flop synchroniser, then level accepted after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync1  <= 1'b0;
            btn_sync2  <= 1'b0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt     <= DB_INIT;
        end else begin
            btn_sync1  <= step_btn;
            btn_sync2  <= btn_sync1;
            db_level_q <= db_level;
            if (btn_sync2 == db_level) begin
                db_cnt <= DB_INIT;
            end else if (db_cnt == '0) begin
                db_level <= btn_sync2;
                db_cnt   <= DB_INIT;
            end else begin
                db_cnt <= db_cnt - 1'b1;
            end
        end
    end

    // Next-state and enable decode; mode changes beat halt, halt beats tick/step
    always_comb begin
        state_d    = state_q;
        cpu_en_d   = 1'b0;
        rate_cnt_d = '0;
        if (hold_active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode_sw == 2'b01)  state_d = S_STEP;
                    else if (mode_sw[1])   state_d = S_RUN;
                end
                S_RUN: begin
                    if (mode_sw == 2'b00)       state_d = S_IDLE;
                    else if (mode_sw == 2'b01)  state_d = S_STEP;
                    else if (at_halt)           state_d = S_HALT;
                    else if (mode_sw == 2'b10)  cpu_en_d = 1'b1;
                    else if (rate_cnt_q >= rate_div) cpu_en_d = 1'b1;
                    else rate_cnt_d = rate_cnt_q + 1'b1;
                end
                S_STEP: begin
                    if (mode_sw == 2'b00)  state_d = S_IDLE;
                    else if (mode_sw[1])   state_d = S_RUN;
                    else if (at_halt)      state_d = S_HALT;
                    else if (step_pulse)   cpu_en_d = 1'b1;
                end
                S_HALT: begin
                    if (mode_sw == 2'b00)  state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered outputs, rate counter and saturating retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cpu_en        <= 1'b0;
            halted        <= 1'b0;
            rate_cnt_q    <= '0;
            retired_count <= '0;
        end else begin
            state_q    <= state_d;
            cpu_en     <= cpu_en_d;
            halted     <= (state_d == S_HALT);
            rate_cnt_q <= rate_cnt_d;
            if (cpu_en_d && (retired_count != '1))
                retired_count <= retired_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_exec_step_controller.sv
// Bench for exec_step_controller: directed scenarios followed by random
// stimulus, every cycle scored against a behavioural model through a queue.
module tb_exec_step_controller;
    localparam int DB   = 4;
    localparam int RH   = 2;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode_sw = 2'b00;
    logic        step_btn = 1'b0;
    logic [7:0]  rate_div = 8'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] halt_addr = 32'h40;
    logic        cpu_en;
    logic        cpu_reset;
    logic [1:0]  state;
    logic        halted;
    logic [3:0]  retired_count;

    exec_step_controller #(
        .PC_WIDTH(32), .RATE_WIDTH(8), .DEBOUNCE_CYCLES(DB),
        .RESET_HOLD(RH), .COUNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .mode_sw(mode_sw), .step_btn(step_btn),
        .rate_div(rate_div), .pc(pc), .halt_addr(halt_addr),
        .cpu_en(cpu_en), .cpu_reset(cpu_reset), .state(state),
        .halted(halted), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       rst;
        logic [1:0] st;
        logic       hl;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   en_seen = 0;
    int   cycle_no = 0;

    // reference model state (spec encoding: 0 IDLE, 1 RUN, 2 STEP, 3 HALT)
    int   since_rel;
    int   m_st;
    int   m_cnt;
    int   waited;
    logic btn_line[$];
    logic obs_win[$];
    logic lvl_now;
    logic lvl_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle_no, act, exp);
        end
    endtask

    // Expected outputs after the coming clock edge, from the current inputs.
    function automatic void model_edge();
        exp_t e;
        logic obs, pulse, all_diff, frozen, nxt_en;
        int   nxt;
        if (reset) begin
            since_rel = 0; m_st = 0; m_cnt = 0; waited = 0;
            btn_line.delete(); btn_line.push_back(1'b0); btn_line.push_back(1'b0);
            obs_win.delete(); lvl_now = 1'b0; lvl_prev = 1'b0;
            e = '{en: 1'b0, rst: 1'b1, st: 2'd0, hl: 1'b0, cnt: 4'd0};
            exp_q.push_back(e);
            return;
        end
        // button seen by the debouncer is the one sampled two edges ago
        obs = btn_line.pop_front();
        btn_line.push_back(step_btn);
        pulse = lvl_now & ~lvl_prev;
        lvl_prev = lvl_now;
        obs_win.push_back(obs);
        if (obs_win.size() > DB) void'(obs_win.pop_front());
        if (obs_win.size() == DB) begin
            all_diff = 1'b1;
            foreach (obs_win[k]) if (obs_win[k] == lvl_now) all_diff = 1'b0;
            if (all_diff) lvl_now = obs;
        end
        if (since_rel < 1000) since_rel++;
        frozen = (since_rel <= RH);
        nxt = m_st;
        nxt_en = 1'b0;
        if (frozen) nxt = 0;
        else if (m_st == 0) begin
            if (mode_sw == 2'd1) nxt = 2;
            else if (mode_sw >= 2'd2) nxt = 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (mode_sw == 2'd0) nxt = 0;
            else if (mode_sw == 2'd1) nxt = 2;
            else nxt = 1;
            if (nxt == m_st && pc == halt_addr) nxt = 3;
            else if (nxt == m_st && m_st == 2) nxt_en = pulse;
            else if (nxt == m_st && mode_sw == 2'd2) nxt_en = 1'b1;
        end else begin
            if (mode_sw == 2'd0) nxt = 0;
        end
        // rate-limited run: tick once at least rate_div cycles have waited
        if (!frozen && m_st == 1 && nxt == 1 && mode_sw == 2'd3) begin
            if (waited >= int'(rate_div)) begin
                nxt_en = 1'b1;
                waited = 0;
            end else waited++;
        end else waited = 0;
        m_st = nxt;
        if (nxt_en && m_cnt < CMAX) m_cnt++;
        e = '{en: nxt_en, rst: frozen, st: 2'(nxt), hl: (nxt == 3), cnt: 4'(m_cnt)};
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input logic r, input logic [1:0] m, input logic b,
                       input logic [7:0] rd, input logic [31:0] p, input logic [31:0] h);
        @(negedge clk);
        reset = r; mode_sw = m; step_btn = b; rate_div = rd; pc = p; halt_addr = h;
        model_edge();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expectation per clock edge and scores every output
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (cpu_en === 1'b1) en_seen++;
                chk("cpu_en", 32'(cpu_en), 32'(e.en));
                chk("cpu_reset", 32'(cpu_reset), 32'(e.rst));
                chk("state", 32'(state), 32'(e.st));
                chk("halted", 32'(halted), 32'(e.hl));
                chk("retired_count", 32'(retired_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [1:0]  m;
        logic        b;
        logic [7:0]  rd;
        logic [31:0] p;
        logic        r;

        // T1: reset for 3 cycles, idle mode
        repeat (3) cyc(1, 2'b00, 0, 8'd0, 32'h0, 32'h40);
        repeat (4) cyc(0, 2'b00, 0, 8'd0, 32'h0, 32'h40);
        // T2: free-run, then hit the halt address
        repeat (8) cyc(0, 2'b10, 0, 8'd0, 32'h0, 32'h40);
        repeat (3) cyc(0, 2'b10, 0, 8'd0, 32'h40, 32'h40);
        // leave HALT, re-enter RUN with pc still at halt_addr
        repeat (2) cyc(0, 2'b00, 0, 8'd0, 32'h40, 32'h40);
        repeat (3) cyc(0, 2'b10, 0, 8'd0, 32'h40, 32'h40);
        repeat (2) cyc(0, 2'b00, 0, 8'd0, 32'h0, 32'h40);

        // T3: rate-limited run, rate_div=3
        cyc(1, 2'b00, 0, 8'd3, 32'h0, 32'h40);
        repeat (2) cyc(0, 2'b00, 0, 8'd3, 32'h0, 32'h40);
        repeat (41) cyc(0, 2'b11, 0, 8'd3, 32'h0, 32'h40);
        settle();
        chk("t3_count", 32'(retired_count), 32'd10);

        // T4: single-step with a bouncy press, then a short glitch
        cyc(1, 2'b00, 0, 8'd0, 32'h0, 32'h40);
        repeat (6) cyc(0, 2'b01, 0, 8'd0, 32'h0, 32'h40);
        settle();
        base = en_seen;
        cyc(0, 2'b01, 1, 8'd0, 32'h0, 32'h40);
        cyc(0, 2'b01, 0, 8'd0, 32'h0, 32'h40);
        repeat (11) cyc(0, 2'b01, 1, 8'd0, 32'h0, 32'h40);
        repeat (12) cyc(0, 2'b01, 0, 8'd0, 32'h0, 32'h40);
        settle();
        chk("t4_press", 32'(en_seen - base), 32'd1);
        base = en_seen;
        repeat (2) cyc(0, 2'b01, 1, 8'd0, 32'h0, 32'h40);
        repeat (12) cyc(0, 2'b01, 0, 8'd0, 32'h0, 32'h40);
        settle();
        chk("t4_glitch", 32'(en_seen - base), 32'd0);

        // T5: saturation of the 4-bit retire counter
        cyc(1, 2'b00, 0, 8'd0, 32'h0, 32'h40);
        repeat (2) cyc(0, 2'b00, 0, 8'd0, 32'h0, 32'h40);
        repeat (24) cyc(0, 2'b10, 0, 8'd0, 32'h0, 32'h40);
        settle();
        chk("t5_saturate", 32'(retired_count), 32'hF);

        // T6: reset pulse mid-run in mode 11 with rate_div=0
        repeat (4) cyc(0, 2'b11, 0, 8'd0, 32'h0, 32'h40);
        cyc(1, 2'b11, 0, 8'd0, 32'h0, 32'h40);
        repeat (6) cyc(0, 2'b11, 0, 8'd0, 32'h0, 32'h40);

        // random stimulus
        m = 2'b10; b = 1'b0; rd = 8'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) b = ~b;
            if ($urandom_range(0, 49) == 0) rd = 8'($urandom_range(0, 6));
            p = ($urandom_range(0, 39) == 0) ? 32'h40 : 32'($urandom_range(0, 63)) & 32'h3C;
            r = ($urandom_range(0, 299) == 0);
            cyc(r, m, b, rd, p, 32'h40);
        end
        repeat (3) settle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
